rx_block_lock_ctrl: RTL and testbench

- Sequences the 32-bit RX gearbox and achieves 64b/66b block alignment.
- Generates the free-running gearbox sequence counter and pause, checks sync headers returned by the gearbox, and runs the block-lock state machine.
- Issues slip pulses to the transceiver bit-slip input until header alignment is found. Declares and monitors block lock.
- Sits between the transceiver RX interface, the RX gearbox and the PCS descrambler/decoder.

---
 rtl/rx_block_lock_ctrl.sv | 153 +++++++++++++++
 tb/tb_rx_block_lock_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_block_lock_ctrl.sv
// RX gearbox sequencer and 64b/66b block-lock controller: free-running sequence/pause,
// sync-header checking, bit-slip requests during hunt, and lock monitoring by bad-header windows.
module rx_block_lock_ctrl #(
  parameter int SEQUENCE_WIDTH = 6,
  parameter int SEQ_MAX        = 32,
  parameter int LOCK_COUNT     = 64,
  parameter int WINDOW         = 64,
  parameter int BAD_MAX        = 16,
  parameter int SLIP_WAIT      = 32
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [1:0]                i_header,
  input  logic                      i_header_valid,
  output logic [SEQUENCE_WIDTH-1:0] o_gearbox_seq,
  output logic                      o_pause,
  output logic                      o_slip,
  output logic                      o_block_lock,
  output logic [7:0]                o_slip_count,
  output logic [1:0]                o_dbg_state
);

  localparam int HDR_MAX = (LOCK_COUNT > WINDOW) ? LOCK_COUNT : WINDOW;
  localparam int HW      = $clog2(HDR_MAX + 1);
  localparam int BW      = $clog2(BAD_MAX + 1);
  localparam int WW      = $clog2(SLIP_WAIT + 1);

  localparam logic [1:0] ST_HUNT      = 2'd0;
  localparam logic [1:0] ST_SLIP_WAIT = 2'd1;
  localparam logic [1:0] ST_LOCKED    = 2'd2;

  localparam logic [SEQUENCE_WIDTH-1:0] SEQ_LAST  = SEQUENCE_WIDTH'(SEQ_MAX);
  localparam logic [HW-1:0]             LOCK_C    = HW'(LOCK_COUNT);
  localparam logic [HW-1:0]             WIN_C     = HW'(WINDOW);
  localparam logic [BW-1:0]             BAD_C     = BW'(BAD_MAX);
  localparam logic [WW-1:0]             WAIT_LAST = WW'(SLIP_WAIT - 1);

  logic [SEQUENCE_WIDTH-1:0] seq_q, seq_d;
  logic                      pause_q, pause_d;
  logic [1:0]                state_q, state_d;
  logic [HW-1:0]             hdr_q, hdr_d, hdr_inc;
  logic [BW-1:0]             bad_q, bad_d, bad_inc;
  logic [WW-1:0]             wait_q, wait_d;
  logic                      lock_q, lock_d;
  logic                      slip_q, slip_d;
  logic [7:0]                slip_cnt_q, slip_cnt_d;
  logic                      hdr_take, hdr_ok, take_slip;

  // Pause is registered so it lines up with the cycle the sequence sits at SEQ_MAX.
  always_comb begin
    seq_d   = (seq_q == SEQ_LAST) ? '0 : seq_q + SEQUENCE_WIDTH'(1);
    pause_d = (seq_d == SEQ_LAST);
  end

  // Headers strobed during a pause cycle are dropped even if the gearbox flags them.
  assign hdr_take = i_header_valid && !pause_q;
  assign hdr_ok   = i_header[1] ^ i_header[0];
  assign hdr_inc  = hdr_q + HW'(1);
  assign bad_inc  = bad_q + BW'(!hdr_ok);

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    bad_d      = bad_q;
    wait_d     = wait_q;
    lock_d     = lock_q;
    slip_d     = 1'b0;
    slip_cnt_d = slip_cnt_q;
    take_slip  = 1'b0;
    unique case (state_q)
      ST_HUNT: begin
        if (hdr_take) begin
          if (!hdr_ok) begin
            take_slip = 1'b1;
          end else if (hdr_inc == LOCK_C) begin
            state_d = ST_LOCKED;
            lock_d  = 1'b1;
            hdr_d   = '0;
            bad_d   = '0;
          end else begin
            hdr_d = hdr_inc;
          end
        end
      end
      ST_SLIP_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = ST_HUNT;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ST_LOCKED: begin
        // Loss of lock is tested first so it wins when the window closes on the last bad header.
        if (hdr_take) begin
          if (bad_inc == BAD_C) begin
            lock_d    = 1'b0;
            take_slip = 1'b1;
          end else if (hdr_inc == WIN_C) begin
            hdr_d = '0;
            bad_d = '0;
          end else begin
            hdr_d = hdr_inc;
            bad_d = bad_inc;
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase
    if (take_slip) begin
      slip_d     = 1'b1;
      slip_cnt_d = (slip_cnt_q == 8'hFF) ? slip_cnt_q : slip_cnt_q + 8'd1;
      hdr_d      = '0;
      bad_d      = '0;
      wait_d     = '0;
      state_d    = ST_SLIP_WAIT;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      seq_q      <= '0;
      pause_q    <= 1'b0;
      state_q    <= ST_HUNT;
      hdr_q      <= '0;
      bad_q      <= '0;
      wait_q     <= '0;
      lock_q     <= 1'b0;
      slip_q     <= 1'b0;
      slip_cnt_q <= '0;
    end else begin
      seq_q      <= seq_d;
      pause_q    <= pause_d;
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      bad_q      <= bad_d;
      wait_q     <= wait_d;
      lock_q     <= lock_d;
      slip_q     <= slip_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

  assign o_gearbox_seq = seq_q;
  assign o_pause       = pause_q;
  assign o_slip        = slip_q;
  assign o_block_lock  = lock_q;
  assign o_slip_count  = slip_cnt_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_rx_block_lock_ctrl.sv
// Randomized bench for rx_block_lock_ctrl: an edge-counting reference model predicts every
// output each cycle, plus directed lock/loss/saturation/async-reset scenarios.
module tb_rx_block_lock_ctrl;

  localparam int SEQ_MAX    = 32;
  localparam int LOCK_COUNT = 64;
  localparam int WINDOW     = 64;
  localparam int BAD_MAX    = 16;
  localparam int SLIP_WAIT  = 32;
  localparam int PERIOD     = SEQ_MAX + 1;

  logic       i_clk;
  logic       i_reset_n;
  logic [1:0] i_header;
  logic       i_header_valid;
  logic [5:0] o_gearbox_seq;
  logic       o_pause;
  logic       o_slip;
  logic       o_block_lock;
  logic [7:0] o_slip_count;
  logic [1:0] o_dbg_state;

  rx_block_lock_ctrl dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_header       (i_header),
    .i_header_valid (i_header_valid),
    .o_gearbox_seq  (o_gearbox_seq),
    .o_pause        (o_pause),
    .o_slip         (o_slip),
    .o_block_lock   (o_block_lock),
    .o_slip_count   (o_slip_count),
    .o_dbg_state    (o_dbg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // reference model: edges since reset, lock flag, header tallies, hunt-resume edge
  int m_k;
  bit m_locked;
  int m_cnt;
  int m_bad;
  int m_ignore_until;
  bit m_slip;
  int m_slips;
  int m_total;
  int last_slip_k;

  function automatic void model_reset();
    m_k = 0; m_locked = 0; m_cnt = 0; m_bad = 0; m_ignore_until = 0;
    m_slip = 0; m_slips = 0; last_slip_k = -1;
  endfunction

  function automatic bit pause_now();
    return (m_k % PERIOD) == SEQ_MAX;
  endfunction

  function automatic void model_slip();
    m_slip = 1;
    m_total++;
    if (m_slips < 255) m_slips++;
    m_cnt = 0;
    m_bad = 0;
    m_ignore_until = m_k + SLIP_WAIT;
  endfunction

  function automatic void model_edge(input logic [1:0] h, input logic v);
    bit accepted;
    bit good;
    accepted = v && !pause_now();
    m_k++;
    m_slip = 0;
    good = (h == 2'b01) || (h == 2'b10);
    if (accepted && m_k > m_ignore_until) begin
      if (!m_locked) begin
        if (!good) model_slip();
        else begin
          m_cnt++;
          if (m_cnt == LOCK_COUNT) begin m_locked = 1; m_cnt = 0; end
        end
      end else begin
        m_cnt++;
        if (!good) m_bad++;
        if (m_bad == BAD_MAX) begin m_locked = 0; model_slip(); end
        else if (m_cnt == WINDOW) begin m_cnt = 0; m_bad = 0; end
      end
    end
  endfunction

  // driver tasks
  task automatic step(input logic [1:0] h, input logic v);
    i_header = h;
    i_header_valid = v;
    @(posedge i_clk);
    model_edge(h, v);
    @(negedge i_clk);
    check("seq", 32'(o_gearbox_seq), 32'(m_k % PERIOD));
    check("pause", 32'(o_pause), 32'(pause_now()));
    check("slip", 32'(o_slip), 32'(m_slip));
    check("lock", 32'(o_block_lock), 32'(m_locked));
    check("slip_count", 32'(o_slip_count), 32'(m_slips));
    if (o_slip) begin
      if (last_slip_k >= 0) check("slip_gap_ok", 32'((m_k - last_slip_k) >= SLIP_WAIT + 1), 32'd1);
      last_slip_k = m_k;
    end
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
  endfunction

  // Issues one header that the DUT will take; pause cycles get a decoy bad header that must be ignored.
  task automatic send_accepted(input logic [1:0] h);
    while (pause_now()) step(bad_hdr(), 1'b1);
    step(h, 1'b1);
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) send_accepted(good_hdr());
  endtask

  task automatic send_window(input int nbad);
    bit bad_pos[WINDOW];
    int placed;
    int idx;
    foreach (bad_pos[i]) bad_pos[i] = 0;
    placed = 0;
    while (placed < nbad) begin
      idx = $urandom_range(0, WINDOW - 1);
      if (!bad_pos[idx]) begin bad_pos[idx] = 1; placed++; end
    end
    for (int i = 0; i < WINDOW; i++) send_accepted(bad_pos[i] ? bad_hdr() : good_hdr());
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    check("rst_seq", 32'(o_gearbox_seq), 32'd0);
    check("rst_pause", 32'(o_pause), 32'd0);
    check("rst_slip", 32'(o_slip), 32'd0);
    check("rst_lock", 32'(o_block_lock), 32'd0);
    check("rst_slip_count", 32'(o_slip_count), 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_total = 0;
    i_reset_n = 1'b0;
    i_header = 2'b00;
    i_header_valid = 1'b0;
    model_reset();
    apply_reset();

    // idle: sequence and pause only
    for (int i = 0; i < 100; i++) step(2'b00, 1'b0);

    // 64 good headers -> lock
    send_good(LOCK_COUNT);
    check("lock_after_64", 32'(o_block_lock), 32'd1);
    check("no_slips_yet", 32'(o_slip_count), 32'd0);

    // hunt interrupted by a bad header, ignored wait, then relock
    apply_reset();
    send_good(10);
    send_accepted(2'b11);
    check("hunt_slip", 32'(o_slip), 32'd1);
    for (int i = 0; i < SLIP_WAIT; i++) step($urandom_range(0, 1) ? bad_hdr() : good_hdr(), 1'b1);
    send_good(LOCK_COUNT - 1);
    check("not_yet_locked", 32'(o_block_lock), 32'd0);
    send_good(1);
    check("relock", 32'(o_block_lock), 32'd1);
    check("one_slip", 32'(o_slip_count), 32'd1);

    // 15 bad holds lock, 16 bad loses it
    send_window(BAD_MAX - 1);
    check("lock_held_15bad", 32'(o_block_lock), 32'd1);
    send_window(BAD_MAX);
    check("lock_lost_16bad", 32'(o_block_lock), 32'd0);
    check("slips_after_loss", 32'(o_slip_count), 32'd2);

    // continuous invalid headers: spacing and saturation
    for (int i = 0; i < 15000 && m_total < 300; i++) step(bad_hdr(), 1'b1);
    check("reached_300_slips", 32'(m_total >= 300), 32'd1);
    check("slip_count_sat", 32'(o_slip_count), 32'd255);

    // lock, go mid-window, async reset, then require a fresh 64
    for (int i = 0; i < SLIP_WAIT + 2; i++) step(2'b00, 1'b0);
    send_good(LOCK_COUNT);
    send_good(20);
    check("locked_before_rst", 32'(o_block_lock), 32'd1);
    apply_reset();
    send_good(LOCK_COUNT - 1);
    check("fresh_63_unlocked", 32'(o_block_lock), 32'd0);
    send_good(1);
    check("fresh_64_locked", 32'(o_block_lock), 32'd1);

    // random soak with varying error density
    for (int i = 0; i < 4000; i++) begin
      int bad_pct;
      bad_pct = (i < 2000) ? 5 : 30;
      step(($urandom_range(0, 99) < bad_pct) ? bad_hdr() : good_hdr(), $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
